mvm_par: RTL and testbench
==========================

MVM_PAR -- requirements
Module: mvm_par

Interface
- REQ-001 The block SHALL have parameter NROWS, default 4, meaning rows of matrix A and length of the output vector.
- REQ-002 The block SHALL have parameter NCOLS, default 4, meaning columns of A and length of input vector B.
- REQ-003 The block SHALL have parameter NLANES, default 2, meaning the number of parallel MAC lanes.
  - NROWS mod NLANES SHALL be 0.
- REQ-004 The block SHALL have parameter IN_W, default 8, meaning signed input element width.
- REQ-005 The block SHALL have parameter OUT_W, default 16, meaning signed accumulator and output width.
- REQ-006 The block SHALL have these ports:
  - clk  in  1  sole clock.
  - reset  in  1  synchronous, active-low reset.
  - s_valid  in  1  input beat valid.
  - s_ready  out  1  input beat accepted when both s_valid and s_ready are high.
  - data_in  in  IN_W  signed element.
  - reuse_a  in  1  skip reloading A on the next job.
  - m_valid  out  1  output beat valid.
  - m_ready  in  1  downstream accept.
  - data_out  out  OUT_W  signed result element.
  - overflow  out  1  result element overflowed; qualified by m_valid.

Function
- REQ-007 The FSM SHALL have the states START, LOAD_A, LOAD_B, COMPUTE and DRAIN.
- REQ-008 START SHALL last 1 cycle with s_ready=0.
  - Next state SHALL be LOAD_B if reuse_a=1 and a_loaded=1; otherwise LOAD_A.
- REQ-009 LOAD_A SHALL accept NROWS*NCOLS beats, row-major, with s_ready=1.
  - Row r SHALL be written to lane bank r mod NLANES.
  - After the last beat: set a_loaded=1 and go to LOAD_B.
- REQ-010 LOAD_B SHALL accept NCOLS beats with s_ready=1, then go to COMPUTE.
- REQ-011 Beats SHALL be counted only on the s_valid&&s_ready cycle; s_valid gaps SHALL stall without data loss.
- REQ-012 COMPUTE SHALL process NROWS/NLANES groups, in ascending order.
  - In group g, lane l SHALL accumulate A[g*NLANES+l][j]*B[j] for j=0..NCOLS-1, one product per cycle per lane.
- REQ-013 Pipeline SHALL be memory read (1) + multiply (1) + accumulate (1).
  - The first data_out of a group SHALL assert m_valid exactly NCOLS+3 cycles after the group starts.
- REQ-014 At group end, the NLANES results SHALL be latched into an output buffer and the FSM SHALL enter DRAIN.
  - DRAIN SHALL present results lane 0 first, one per m_valid&&m_ready handshake.
- REQ-015 After the last lane drains: go to COMPUTE for the next group, or to START after the final group.
- REQ-016 While m_valid=1 and m_ready=0, data_out and overflow SHALL hold stable.
- REQ-017 s_ready SHALL be 0 in COMPUTE, DRAIN and START.
- REQ-018 Products SHALL be full 2*IN_W signed; accumulation SHALL be OUT_W signed.
  - overflow SHALL be sticky per output element: set if any accumulate step leaves the signed OUT_W range.
- REQ-019 Whole outputs per job SHALL be exactly NROWS, in row order 0..NROWS-1.
- REQ-020 reuse_a SHALL be sampled only in START.
  - reuse_a=1 with a_loaded=0 SHALL behave as 0.
- REQ-021 NLANES=NROWS, NLANES=1 and NCOLS=1 SHALL all be supported.

Reset
- REQ-022 When reset=0 at a clk edge, the block SHALL set:
  - state=START, a_loaded=0.
  - all counters 0.
  - s_ready=0, m_valid=0, data_out=0, overflow=0.
- REQ-023 Reset asserted mid-job SHALL abandon the job.
  - No further m_valid until a new job completes.
  - Stored A SHALL be treated as invalid.

Configuration
- REQ-024 With MVM_SAT_EN defined, an overflowing accumulator SHALL clamp to +2^(OUT_W-1)-1 or -2^(OUT_W-1), and remain clamped for that element.
  - overflow SHALL still be set.
- REQ-025 Without MVM_SAT_EN, the accumulator SHALL wrap modulo 2^OUT_W, with overflow set.

Structure
- REQ-026 defines_pkg SHALL hold the default NROWS/NCOLS/NLANES/IN_W/OUT_W constants and the FSM state enum typedef.
- REQ-027 Each lane SHALL be one instance of sub-module mvm_mac_lane.
  - It SHALL contain the multiply, accumulate and overflow/saturation logic, parametrised by IN_W and OUT_W.
- REQ-028 Lane banks SHALL use the existing single-port memory module, depth (NROWS/NLANES)*NCOLS.

Verification
- REQ-029 Defaults, A=all 1, B=1,2,3,4, m_ready=1 -> four outputs of 10, overflow=0.
  - First m_valid SHALL be 7 cycles after COMPUTE entry.
- REQ-030 Second job with reuse_a=1, B=-1,-1,-1,-1 -> only 4 input beats accepted, outputs -4,-4,-4,-4.
- REQ-031 OUT_W=16, NCOLS=4, A row0=127, B=127 -> 64516 exceeds +32767:
  - With MVM_SAT_EN: output 32767, overflow=1.
  - Without MVM_SAT_EN: output -1020, overflow=1.
- REQ-032 m_ready toggled 1-0-0-1 during DRAIN -> data_out stable while stalled; no duplicate or lost elements.
- REQ-033 Random s_valid gaps during load; reset=0 pulsed mid-COMPUTE -> m_valid=0 next cycle; following reuse_a=1 job SHALL still reload A.

Source files
------------

// File: rtl/defines_pkg.sv
// Shared constants, FSM state type and a width helper for the mvm_par slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package defines_pkg;

    localparam int DEF_NROWS  = 4;
    localparam int DEF_NCOLS  = 4;
    localparam int DEF_NLANES = 2;
    localparam int DEF_IN_W   = 8;
    localparam int DEF_OUT_W  = 16;

    typedef enum logic [2:0] {
        START,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        DRAIN
    } state_t;

    // Counter/address width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvm_par_if.sv
// Input element stream, output result stream and job control of mvm_par.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both streams; reuse_a is a level sampled by the block.
interface mvm_par_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
);
    logic                    s_valid;
    logic                    s_ready;
    logic signed [IN_W-1:0]  data_in;
    logic                    reuse_a;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [OUT_W-1:0] data_out;
    logic                    overflow;

    modport master (
        output s_valid, data_in, reuse_a, m_ready,
        input  s_ready, m_valid, data_out, overflow
    );

    modport slave (
        input  s_valid, data_in, reuse_a, m_ready,
        output s_ready, m_valid, data_out, overflow
    );
endinterface

// File: rtl/mvm_mac_lane.sv
// One MAC lane: full-width signed product, OUT_W signed accumulate, sticky overflow.
// Latency: product registered 1 cycle after in_vld, accumulator updated the cycle after.
// Backpressure: none, operands are sequenced by the caller. MVM_SAT_EN clamps instead of wrapping.
module mvm_mac_lane #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    in_vld,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    output logic signed [OUT_W-1:0] acc,
    output logic                    ovf
);
    localparam int PW = 2 * IN_W;
    localparam int SW = ((OUT_W > PW) ? OUT_W : PW) + 1;

`ifdef MVM_SAT_EN
    localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
`endif

    logic signed [PW-1:0] prod;
    logic                 prod_vld;
    logic signed [SW-1:0] sum;
    logic                 step_ovf;

    // Sum has headroom; a step overflows when the bits above OUT_W-1 disagree with its sign.
    always_comb begin
        sum      = SW'(acc) + SW'(prod);
        step_ovf = !((&sum[SW-1:OUT_W-1]) || !(|sum[SW-1:OUT_W-1]));
    end

    // Multiply stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prod     <= '0;
            prod_vld <= 1'b0;
        end else begin
            prod     <= PW'(a) * PW'(b);
            prod_vld <= in_vld;
        end
    end

    // Accumulate stage; clr restarts the element at the beginning of each group.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (prod_vld) begin
`ifdef MVM_SAT_EN
            if (!ovf) acc <= step_ovf ? (sum[SW-1] ? SAT_MIN : SAT_MAX) : sum[OUT_W-1:0];
`else
            acc <= sum[OUT_W-1:0];
`endif
            ovf <= ovf | step_ovf;
        end
    end
endmodule

// File: rtl/sp_ram.sv
// Single-port RAM with one shared address for write and registered read.
// Latency: read data valid 1 cycle after the address is presented.
// Backpressure: none.
module sp_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];

    // Write-first is not needed: loads and reads never target the same cycle's data.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mvm_par.sv
// Matrix-vector multiply y = A*B with NLANES parallel MAC lanes; A may be kept across jobs.
// Latency: first result of a group valid NCOLS+3 cycles after the group starts computing.
// Backpressure: s_ready only in LOAD_A/LOAD_B; results held stable while m_ready is low. Option macro: MVM_SAT_EN.
module mvm_par
    import defines_pkg::*;
#(
    parameter int NROWS  = DEF_NROWS,
    parameter int NCOLS  = DEF_NCOLS,
    parameter int NLANES = DEF_NLANES,   // must divide NROWS
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic      clk,
    input  logic      reset,
    mvm_par_if.slave  bus
);
    localparam int NGRP  = NROWS / NLANES;
    localparam int DEPTH = NGRP * NCOLS;
    localparam int AW    = clog2_min1(DEPTH);
    localparam int CW    = clog2_min1(NCOLS + 3);
    localparam int BW    = clog2_min1(NCOLS);
    localparam int LW    = clog2_min1(NLANES);
    localparam int GW    = clog2_min1(NGRP);

    state_t                  state, state_nx;
    logic                    a_loaded;
    logic [CW-1:0]           col;    // beat column while loading, pipeline step in COMPUTE
    logic [LW-1:0]           lane;   // bank of the row being loaded, drain pointer in DRAIN
    logic [GW-1:0]           grp;
    logic signed [IN_W-1:0]  b_reg [NCOLS];
    logic signed [IN_W-1:0]  b_q;
    logic                    rd_vld;
    logic [AW-1:0]           addr;
    logic [IN_W-1:0]         a_rd [NLANES];
    logic signed [OUT_W-1:0] acc [NLANES];
    logic                    ovf [NLANES];
    logic signed [OUT_W-1:0] obuf [NLANES];
    logic                    obuf_ovf [NLANES];
    logic                    m_vld;
    logic                    hs_in, hs_out, issue, clr;
    logic                    last_col, last_lane, last_grp, last_step;

    assign hs_in     = bus.s_valid && bus.s_ready;
    assign hs_out    = m_vld && bus.m_ready;
    assign last_col  = (col == CW'(NCOLS - 1));
    assign last_step = (col == CW'(NCOLS + 2));
    assign last_lane = (lane == LW'(NLANES - 1));
    assign last_grp  = (grp == GW'(NGRP - 1));
    assign issue     = (state == COMPUTE) && (col < CW'(NCOLS));
    assign clr       = (state == COMPUTE) && (col == '0);
    // Loading and computing both walk grp-major, column-minor through each bank.
    assign addr      = AW'(32'(grp) * 32'(NCOLS) + 32'(col));

    assign bus.s_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign bus.m_valid  = m_vld;
    assign bus.data_out = obuf[lane];
    assign bus.overflow = obuf_ovf[lane];

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            START:   state_nx = (bus.reuse_a && a_loaded) ? LOAD_B : LOAD_A;
            LOAD_A:  if (hs_in && last_col && last_lane && last_grp) state_nx = LOAD_B;
            LOAD_B:  if (hs_in && last_col) state_nx = COMPUTE;
            COMPUTE: if (last_step) state_nx = DRAIN;
            DRAIN:   if (hs_out && last_lane) state_nx = last_grp ? START : COMPUTE;
            default: state_nx = START;
        endcase
    end

    // State register, beat/step/lane/group counters and the output-valid flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= START;
            a_loaded <= 1'b0;
            col      <= '0;
            lane     <= '0;
            grp      <= '0;
            m_vld    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                START: begin
                    col  <= '0;
                    lane <= '0;
                    grp  <= '0;
                end
                LOAD_A: if (hs_in) begin
                    col <= last_col ? '0 : col + 1'b1;
                    if (last_col) begin
                        lane <= last_lane ? '0 : lane + 1'b1;
                        if (last_lane) grp <= last_grp ? '0 : grp + 1'b1;
                        if (last_lane && last_grp) a_loaded <= 1'b1;
                    end
                end
                LOAD_B: if (hs_in) col <= last_col ? '0 : col + 1'b1;
                COMPUTE: begin
                    col <= last_step ? '0 : col + 1'b1;
                    if (last_step) m_vld <= 1'b1;
                end
                DRAIN: if (hs_out) begin
                    lane <= last_lane ? '0 : lane + 1'b1;
                    if (last_lane) begin
                        m_vld <= 1'b0;
                        grp   <= last_grp ? '0 : grp + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Capture B and launch the B operand in step with the bank read.
    always_ff @(posedge clk) begin
        if (state == LOAD_B && hs_in) b_reg[col[BW-1:0]] <= bus.data_in;
        if (issue) b_q <= b_reg[col[BW-1:0]];
    end

    // Operand-valid for the lanes, aligned with the registered bank read.
    always_ff @(posedge clk) begin
        if (!reset) rd_vld <= 1'b0;
        else        rd_vld <= issue;
    end

    // Freeze the group's results so DRAIN can stall without disturbing the lanes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int l = 0; l < NLANES; l++) begin
                obuf[l]     <= '0;
                obuf_ovf[l] <= 1'b0;
            end
        end else if (state == COMPUTE && last_step) begin
            for (int l = 0; l < NLANES; l++) begin
                obuf[l]     <= acc[l];
                obuf_ovf[l] <= ovf[l];
            end
        end
    end

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        sp_ram #(.W(IN_W), .DEPTH(DEPTH), .AW(AW)) u_bank (
            .clk   (clk),
            .we    ((state == LOAD_A) && hs_in && (lane == LW'(l))),
            .addr  (addr),
            .wdata (bus.data_in),
            .rdata (a_rd[l])
        );

        mvm_mac_lane #(.IN_W(IN_W), .OUT_W(OUT_W)) u_mac (
            .clk    (clk),
            .reset  (reset),
            .clr    (clr),
            .in_vld (rd_vld),
            .a      (a_rd[l]),
            .b      (b_q),
            .acc    (acc[l]),
            .ovf    (ovf[l])
        );
    end
endmodule

// File: tb/tb_mvm_par.sv
// Directed bench for mvm_par at default parameters.
// Each job loads A/B, checks first-result latency, drains with a ready pattern and compares results.
// Includes A reuse, overflow, output stalls, input gaps and a mid-compute reset.
module tb_mvm_par;
    logic clk = 1'b0;
    logic reset;

    mvm_par_if bus ();

    mvm_par dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic signed [7:0] a_vec [16];
    logic signed [7:0] b_vec [4];
    int exp_d [4];
    int exp_o [4];
    int got_d [4];
    int got_o [4];
    int got_n;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Offer one beat after 'gap' idle cycles; returns at the negedge after it is taken.
    task automatic push(input logic signed [7:0] v, input int gap);
        int t = 0;
        bus.s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.s_valid = 1'b1;
        bus.data_in = v;
        while (!bus.s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("push_timeout", t, 0);
        else @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic load(input logic reuse, input logic with_a, input int max_gap);
        bus.reuse_a = reuse;
        if (with_a)
            for (int i = 0; i < 16; i++) push(a_vec[i], int'($urandom_range(0, max_gap)));
        for (int j = 0; j < 4; j++) push(b_vec[j], int'($urandom_range(0, max_gap)));
    endtask

    // Called in the first COMPUTE cycle.
    task automatic wait_first(input string tag);
        int n = 0;
        check({tag, "_sready_off"}, int'(bus.s_ready), 0);
        while (!bus.m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 7);
    endtask

    // Drain four results with m_ready following pat (bit 0 first, repeating).
    task automatic collect(input string tag, input logic [3:0] pat);
        int cyc = 0;
        logic hold_pending = 1'b0;
        int hold_d = 0;
        int hold_o = 0;
        got_n = 0;
        for (int i = 0; i < 4; i++) begin
            got_d[i] = -99999;
            got_o[i] = -1;
        end
        while (got_n < 4 && cyc < 200) begin
            if (hold_pending) begin
                check({tag, "_stall_valid"}, int'(bus.m_valid), 1);
                check({tag, "_stall_data"}, int'(bus.data_out), hold_d);
                check({tag, "_stall_ovf"}, int'(bus.overflow), hold_o);
            end
            bus.m_ready  = pat[2'(cyc)];
            hold_pending = bus.m_valid && !bus.m_ready;
            hold_d       = int'(bus.data_out);
            hold_o       = int'(bus.overflow);
            if (bus.m_valid && bus.m_ready) begin
                got_d[got_n] = int'(bus.data_out);
                got_o[got_n] = int'(bus.overflow);
                got_n++;
            end
            @(negedge clk);
            cyc++;
        end
        if (got_n < 4) check({tag, "_collect_timeout"}, got_n, 4);
        check({tag, "_no_extra"}, int'(bus.m_valid), 0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            check($sformatf("%s_ovf%0d", tag, i), got_o[i], exp_o[i]);
        end
    endtask

    initial begin
        logic seen;
        reset       = 1'b0;
        bus.s_valid = 1'b0;
        bus.data_in = '0;
        bus.reuse_a = 1'b0;
        bus.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_s_ready", int'(bus.s_ready), 0);
        check("rst_m_valid", int'(bus.m_valid), 0);
        check("rst_data_out", int'(bus.data_out), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        reset = 1'b1;

        // Job 1: A all ones, B = 1..4 -> 10 per row.
        for (int i = 0; i < 16; i++) a_vec[i] = 8'sd1;
        b_vec[0] = 8'sd1; b_vec[1] = 8'sd2; b_vec[2] = 8'sd3; b_vec[3] = 8'sd4;
        for (int i = 0; i < 4; i++) begin exp_d[i] = 10; exp_o[i] = 0; end
        load(1'b0, 1'b1, 0);
        wait_first("j1");
        collect("j1", 4'b1111);

        // Job 2: reuse A, only B = -1 x4 is sent -> -4 per row.
        for (int j = 0; j < 4; j++) b_vec[j] = -8'sd1;
        for (int i = 0; i < 4; i++) begin exp_d[i] = -4; exp_o[i] = 0; end
        load(1'b1, 1'b0, 0);
        wait_first("j2");
        collect("j2", 4'b1111);

        // Job 3: overflow both ways, drained with m_ready 1-0-0-1.
        for (int c = 0; c < 4; c++) begin
            a_vec[c]      = 8'sd127;
            a_vec[4 + c]  = 8'sd0;
            a_vec[8 + c]  = 8'sd1;
            a_vec[12 + c] = -8'sd128;
            b_vec[c]      = 8'sd127;
        end
`ifdef MVM_SAT_EN
        exp_d[0] = 32767;  exp_d[3] = -32768;
`else
        exp_d[0] = -1020;  exp_d[3] = 512;
`endif
        exp_o[0] = 1;
        exp_d[1] = 0;   exp_o[1] = 0;
        exp_d[2] = 508; exp_o[2] = 0;
        exp_o[3] = 1;
        load(1'b0, 1'b1, 0);
        wait_first("j3");
        collect("j3", 4'b1001);

        // Job 4: gapped load, then reset in the middle of COMPUTE.
        for (int i = 0; i < 16; i++) a_vec[i] = 8'sd2;
        for (int j = 0; j < 4; j++) b_vec[j] = 8'sd1;
        load(1'b0, 1'b1, 2);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.reuse_a = 1'b1;
        @(negedge clk);
        check("abort_m_valid", int'(bus.m_valid), 0);
        check("abort_s_ready", int'(bus.s_ready), 0);
        reset = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.m_valid) seen = 1'b1;
        end
        check("abort_quiet", int'(seen), 0);

        // Job 5: reuse_a requested after reset must still reload A; A[r][c] = r-c.
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) a_vec[r * 4 + c] = 8'(r - c);
        b_vec[0] = 8'sd1; b_vec[1] = 8'sd2; b_vec[2] = 8'sd3; b_vec[3] = 8'sd4;
        exp_d[0] = -20; exp_d[1] = -10; exp_d[2] = 0; exp_d[3] = 10;
        for (int i = 0; i < 4; i++) exp_o[i] = 0;
        load(1'b1, 1'b1, 2);
        wait_first("j5");
        collect("j5", 4'b0110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
